// File: rtl/video_core_elastic_stages.sv
// Elastic valid/ready pipeline of STAGE skid (SKID=1) or plain (SKID=0) stages carrying RGB and
// vga_fc_t, with flush and occupancy. Optional stats ports: define VIDEO_CORE_STAGES_STATS_EN.
package vga_pkg;
  typedef struct packed {
    logic sof;
    logic eol;
    logic de;
    logic hsync;
    logic vsync;
  } vga_fc_t;
endpackage

module video_core_elastic_stages
  import vga_pkg::*;
#(
  parameter int unsigned RGB_SIZE = 12,
  parameter int unsigned STAGE    = 2,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CNT_W    = $clog2(2 * STAGE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stage_in_vld,
  output logic                stage_in_rdy,
  input  vga_fc_t             stage_in_fc,
  input  logic [RGB_SIZE-1:0] stage_in_rgb,
  input  logic                stage_out_rdy,
  output logic                stage_out_vld,
  output vga_fc_t             stage_out_fc,
  output logic [RGB_SIZE-1:0] stage_out_rgb,
  output logic [CNT_W-1:0]    occupancy,
  output logic                empty
`ifdef VIDEO_CORE_STAGES_STATS_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [0:0]          full_seen
`endif
);

  localparam int unsigned W = $bits(vga_fc_t) + RGB_SIZE;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} skid_st_e;

  // Index i is the input side of stage i; index i+1 is its output side.
  logic [STAGE:0] vld;
  logic [STAGE:0] rdy;
  logic [W-1:0]   dat [STAGE+1];

  logic             in_xfer, out_xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign vld[0]     = stage_in_vld;
  assign dat[0]     = {stage_in_fc, stage_in_rgb};
  assign rdy[STAGE] = stage_out_rdy;

  for (genvar i = 0; i < STAGE; i++) begin : g_stage
    if (SKID != 0) begin : g_skid
      skid_st_e     st_q;
      logic [W-1:0] main_q, skid_q;
      logic         rdy_q;
      logic         in_x, out_x;

      assign in_x     = vld[i] & rdy_q;
      assign out_x    = (st_q != StEmpty) & rdy[i+1];
      assign rdy[i]   = rdy_q;
      assign vld[i+1] = (st_q != StEmpty);
      assign dat[i+1] = main_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          st_q   <= StEmpty;
          main_q <= '0;
          skid_q <= '0;
          rdy_q  <= 1'b1;
        end else if (flush) begin
          st_q  <= StEmpty;
          rdy_q <= 1'b1;
        end else begin
          unique case (st_q)
            StEmpty: begin
              if (in_x) begin
                main_q <= dat[i];
                st_q   <= StOne;
              end
            end
            StOne: begin
              if (in_x && out_x) begin
                main_q <= dat[i];
              end else if (out_x) begin
                st_q <= StEmpty;
              end else if (in_x) begin
                skid_q <= dat[i];
                st_q   <= StTwo;
                rdy_q  <= 1'b0;
              end
            end
            StTwo: begin
              if (out_x) begin
                main_q <= skid_q;
                st_q   <= StOne;
                rdy_q  <= 1'b1;
              end
            end
            default: begin
              st_q  <= StEmpty;
              rdy_q <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_plain
      logic         v_q;
      logic [W-1:0] d_q;

      // Ready ripples back: this stage can load unless it and every stage after it is full.
      assign rdy[i]   = stage_out_rdy | ~(&vld[STAGE:i+1]);
      assign vld[i+1] = v_q;
      assign dat[i+1] = d_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (flush) begin
          v_q <= 1'b0;
        end else if (rdy[i]) begin
          v_q <= vld[i];
          if (vld[i]) begin
            d_q <= dat[i];
          end
        end
      end
    end
  end

  assign stage_in_rdy                  = rdy[0] & ~flush;
  assign stage_out_vld                 = vld[STAGE] & ~flush;
  assign {stage_out_fc, stage_out_rgb} = dat[STAGE];

  assign in_xfer  = stage_in_vld & stage_in_rdy;
  assign out_xfer = stage_out_vld & stage_out_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign occupancy = cnt_q;
  assign empty     = (cnt_q == '0);

`ifdef VIDEO_CORE_STAGES_STATS_EN
  localparam logic [CNT_W-1:0] CapC = CNT_W'((SKID != 0) ? 2 * STAGE : STAGE);

  logic [15:0] stall_q;
  logic        full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      full_q  <= 1'b0;
    end else if (flush) begin
      stall_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (stage_out_vld && !stage_out_rdy && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (cnt_d == CapC) begin
        full_q <= 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign full_seen = full_q;
`endif

endmodule
